hsv_core_wb_arbiter: RTL and testbench



---
 rtl/hsv_core_pkg.sv | 25 ++
 rtl/hsv_core_rr_arbiter.sv | 43 ++++
 rtl/hsv_core_wb_arbiter.sv | 101 ++++++++++
 tb/tb_hsv_core_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_core_pkg.sv
// Shared core types for the issue/writeback path: register address, data word,
// per-register mask, and the writeback requester numbering.
package hsv_core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int WB_NUM_REQ = 5;

  typedef logic [REG_ADDR_W-1:0]      reg_addr;
  typedef logic [XLEN-1:0]            word;
  typedef logic [(1<<REG_ADDR_W)-1:0] reg_mask;

  typedef enum logic [2:0] {
    WB_ALU,
    WB_FOO,
    WB_MEM,
    WB_BRANCH,
    WB_CTRLSTATUS
  } wb_req_idx_t;

  function automatic reg_mask reg_onehot(input reg_addr addr);
    return reg_mask'(1) << addr;
  endfunction

endpackage

// File: rtl/hsv_core_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last
// winner (with wrap), plus the pointer that remembers that winner.
module hsv_core_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_core,
  input  logic             rst_core,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_reg;
  logic             found;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_reg) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  // Requester 0 is scanned first out of reset.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      last_reg <= IDX_W'(N - 1);
    end else if (advance) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/hsv_core_wb_arbiter.sv
// Writeback arbiter: shares the regfile write port and commit_mask among the
// execution units. Optional conflict counter enabled by HSV_WB_ARB_PERF_EN.
module hsv_core_wb_arbiter
  import hsv_core_pkg::*;
#(
  parameter  int NUM_REQ = WB_NUM_REQ,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    flush_req,
  output logic                    flush_ack,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  reg_addr [NUM_REQ-1:0]   req_rd_addr,
  input  word [NUM_REQ-1:0]       req_rd_data,
  input  logic [NUM_REQ-1:0]      req_rd_we,
  output reg_addr                 wr_addr,
  output word                     wr_data,
  output logic                    wr_en,
  output reg_mask                 commit_mask
`ifdef HSV_WB_ARB_PERF_EN
 ,output logic [31:0]             conflict_cnt
`endif
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               fire;
  reg_addr            sel_addr;
  word                sel_data;
  logic               sel_write;

  reg_addr wr_addr_reg;
  word     wr_data_reg;
  logic    wr_en_reg;
  reg_mask commit_mask_reg;
  logic    flush_ack_reg;

  // Masking the requests during flush keeps both grant and pointer frozen.
  assign arb_req = flush_req ? '0 : req_valid_i;

  hsv_core_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .req       (arb_req),
    .advance   (fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready_o = grant;
  assign fire        = |grant;
  assign sel_addr    = req_rd_addr[grant_idx];
  assign sel_data    = req_rd_data[grant_idx];
  assign sel_write   = req_rd_we[grant_idx] && (sel_addr != '0);

  // x0 writes and no-write retirements produce neither a write nor a commit bit.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      commit_mask_reg <= '0;
      flush_ack_reg   <= 1'b1;
    end else begin
      flush_ack_reg <= flush_req;
      if (fire) begin
        wr_en_reg       <= sel_write;
        wr_addr_reg     <= sel_addr;
        wr_data_reg     <= sel_data;
        commit_mask_reg <= sel_write ? reg_onehot(sel_addr) : '0;
      end else begin
        wr_en_reg       <= 1'b0;
        commit_mask_reg <= '0;
      end
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign commit_mask = commit_mask_reg;
  assign flush_ack   = flush_ack_reg;

`ifdef HSV_WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_reg;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      conflict_cnt_reg <= '0;
    end else if (!flush_req && ($countones(req_valid_i) >= 2) && (conflict_cnt_reg != '1)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_hsv_core_wb_arbiter.sv
// Scoreboard bench for hsv_core_wb_arbiter: directed scenarios followed by
// randomized traffic, checked against a round-robin reference model.
module tb_hsv_core_wb_arbiter;
  import hsv_core_pkg::*;

  localparam int NR = 5;

  logic            clk_core;
  logic            rst_core;
  logic            flush_req;
  logic            flush_ack;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_ready_o;
  reg_addr [NR-1:0] req_rd_addr;
  word [NR-1:0]    req_rd_data;
  logic [NR-1:0]   req_rd_we;
  reg_addr         wr_addr;
  word             wr_data;
  logic            wr_en;
  reg_mask         commit_mask;
`ifdef HSV_WB_ARB_PERF_EN
  logic [31:0]     conflict_cnt;
`endif

  hsv_core_wb_arbiter #(.NUM_REQ(NR)) dut (
    .clk_core    (clk_core),
    .rst_core    (rst_core),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rd_addr (req_rd_addr),
    .req_rd_data (req_rd_data),
    .req_rd_we   (req_rd_we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .commit_mask (commit_mask)
`ifdef HSV_WB_ARB_PERF_EN
   ,.conflict_cnt(conflict_cnt)
`endif
  );

  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  typedef struct {
    logic        wr_en;
    reg_addr     wr_addr;
    word         wr_data;
    reg_mask     commit_mask;
    logic        flush_ack;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Requester-side state: what each unit is currently offering.
  logic [NR-1:0]    v;
  reg_addr [NR-1:0] a;
  word [NR-1:0]     d;
  logic [NR-1:0]    w;

  // Reference model state.
  int          m_last;
  reg_addr     m_addr;
  word         m_data;
  logic [31:0] m_cnt;
  int          last_fire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int model_grant(input logic [NR-1:0] vv, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (vv[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check the combinational grant, predict the next edge.
  task automatic step(input logic fl, input logic rs);
    int g;
    logic [NR-1:0] er;
    exp_t e;
    @(posedge clk_core);
    #2;
    rst_core    = rs;
    flush_req   = fl;
    req_valid_i = v;
    req_rd_addr = a;
    req_rd_data = d;
    req_rd_we   = w;
    @(negedge clk_core);
    g  = (rs || fl) ? -1 : model_grant(v, m_last);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    if (!rs) chk("req_ready_o", 32'(req_ready_o), 32'(er));
    if (rs) begin
      m_last = NR - 1;
      m_addr = '0;
      m_data = '0;
      m_cnt  = '0;
      e.wr_en = 1'b0;
      e.commit_mask = '0;
      e.flush_ack = 1'b1;
      last_fire = -1;
    end else begin
      e.flush_ack = fl;
      if (!fl && $countones(v) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (g >= 0) begin
        m_last = g;
        m_addr = a[g];
        m_data = d[g];
        e.wr_en = w[g] && (a[g] != 0);
        e.commit_mask = e.wr_en ? (reg_mask'(1) << a[g]) : '0;
      end else begin
        e.wr_en = 1'b0;
        e.commit_mask = '0;
      end
      last_fire = g;
    end
    e.wr_addr = m_addr;
    e.wr_data = m_data;
    e.cnt     = m_cnt;
    exp_q.push_back(e);
    $display("cyc t=%0t rst=%0b flush=%0b valid=%05b grant=%0d", $time, rs, fl, v, g);
  endtask

  // Monitor: one registered output set per edge, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_core);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(e.wr_addr));
        chk("wr_data", wr_data, e.wr_data);
        chk("commit_mask", commit_mask, e.commit_mask);
        chk("flush_ack", 32'(flush_ack), 32'(e.flush_ack));
`ifdef HSV_WB_ARB_PERF_EN
        chk("conflict_cnt", conflict_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    rst_core = 1'b1; flush_req = 1'b0;
    req_valid_i = '0; req_rd_addr = '0; req_rd_data = '0; req_rd_we = '0;
    v = '0; a = '0; d = '0; w = '0;
    m_last = NR - 1; m_addr = '0; m_data = '0; m_cnt = '0; last_fire = -1;

    repeat (3) step(1'b0, 1'b1);

    // Single requester 2 writing x7.
    v[2] = 1'b1; a[2] = 5'd7; d[2] = 32'hDEADBEEF; w[2] = 1'b1;
    step(1'b0, 1'b0);
    v = '0;
    step(1'b0, 1'b0);

    // All five continuously valid: rotation 0..4 twice.
    for (int i = 0; i < NR; i++) begin
      v[i] = 1'b1; a[i] = reg_addr'(i + 10); d[i] = $urandom; w[i] = 1'b1;
    end
    repeat (10) step(1'b0, 1'b0);
    v = '0;

    // x0 destination and a no-write retirement.
    v[0] = 1'b1; a[0] = '0; d[0] = 32'h1234_5678; w[0] = 1'b1;
    step(1'b0, 1'b0);
    v = '0;
    v[1] = 1'b1; a[1] = 5'd5; d[1] = 32'h0BAD_F00D; w[1] = 1'b0;
    step(1'b0, 1'b0);
    v = '0;

    // last=1: 3 before 1; then with last=3, lone requester 1 wraps.
    v[1] = 1'b1; a[1] = 5'd1; d[1] = 32'h11; w[1] = 1'b1;
    v[3] = 1'b1; a[3] = 5'd3; d[3] = 32'h33; w[3] = 1'b1;
    step(1'b0, 1'b0);
    if (last_fire >= 0) v[last_fire] = 1'b0;
    step(1'b0, 1'b0);
    if (last_fire >= 0) v[last_fire] = 1'b0;
    v[3] = 1'b1;
    step(1'b0, 1'b0);
    v = '0;
    v[1] = 1'b1;
    step(1'b0, 1'b0);
    v = '0;

    // Two-cycle flush with everyone valid.
    v = '1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    v = '0;

    // Reset right after a fire; pointer back to requester 0.
    v[4] = 1'b1; a[4] = 5'd31; d[4] = 32'hCAFE_0004; w[4] = 1'b1;
    step(1'b0, 1'b0);
    v = '0;
    step(1'b0, 1'b1);
    v = '1;
    repeat (3) step(1'b0, 1'b0);
    v = '0;
    step(1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v[i] && ($urandom % 3 == 0)) begin
          v[i] = 1'b1;
          a[i] = ($urandom % 4 == 0) ? reg_addr'(0) : reg_addr'($urandom);
          d[i] = $urandom;
          w[i] = ($urandom % 4 != 0);
        end
      end
      if ($urandom % 80 == 0) begin
        v = '0;
        step(1'b0, 1'b1);
      end else begin
        step(($urandom % 10 == 0), 1'b0);
        if (last_fire >= 0) v[last_fire] = 1'b0;
      end
    end

    v = '0;
    step(1'b0, 1'b0);
    repeat (3) @(posedge clk_core);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
